mix_word_serializer: RTL

Downstream consumer of the eight-word 32-bit mixing stage. It snapshots all state words in one cycle and streams them out one word per handshake over a valid/ready interface. While streaming it folds the words into a rotate-XOR signature. After the last word it pulses the signature and counts completed frames, so a checker or logger can compare runs without sampling the live state.

---
 rtl/mix_word_serializer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mix_word_serializer.sv
// mix_word_serializer
//   Takes a one-cycle snapshot of NWORDS state words from the mixing stage and
//   streams them out one word per valid/ready handshake. While streaming, the
//   words are folded into a rotate-XOR signature. The signature is published
//   with a one-cycle sig_valid pulse after the last word, and frame_cnt counts
//   completed frames (16-bit, wraps).
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   cap_valid/ready    snapshot handshake; cap_data word i at [i*WIDTH +: WIDTH]
//   out_valid/ready    word stream handshake
//   out_data/index     current word and its index; out_last marks index NWORDS-1
//   sig_valid, sig     one-cycle pulse and signature of the last completed frame
//   frame_cnt          number of completed frames
//
// States
//   IDLE | waiting for a snapshot request, cap_ready high
//   SEND | streaming buffered words, out_valid high
module mix_word_serializer #(
  parameter int WIDTH  = 32,
  parameter int NWORDS = 8,
  parameter int IDXW   = $clog2(NWORDS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cap_valid,
  output logic                      cap_ready,
  input  logic [WIDTH*NWORDS-1:0]   cap_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [IDXW-1:0]           out_index,
  output logic                      out_last,
  output logic                      sig_valid,
  output logic [WIDTH-1:0]          sig,
  output logic [15:0]               frame_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  buf_q [NWORDS];
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  sig_q;
  logic              sig_valid_q;
  logic [15:0]       frame_cnt_q;

  logic              capture;
  logic              handshake;
  logic              at_last;
  logic [WIDTH-1:0]  cur_word;
  logic [WIDTH-1:0]  acc_next;

  assign cur_word  = buf_q[idx_q];
  assign at_last   = (idx_q == LAST_IDX);
  assign capture   = cap_valid && cap_ready;
  assign handshake = out_valid && out_ready;
  // rotate-left-by-one of the running accumulator, then fold in the word
  assign acc_next  = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]} ^ cur_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cap_ready = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cap_ready = 1'b1;
        if (cap_valid) state_d = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready && at_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) buf_q[i] <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      sig_q       <= '0;
      sig_valid_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sig_valid_q <= 1'b0;
      if (capture) begin
        for (int i = 0; i < NWORDS; i++) buf_q[i] <= cap_data[i*WIDTH +: WIDTH];
        idx_q <= '0;
        acc_q <= '0;
      end else if (handshake) begin
        acc_q <= acc_next;
        if (at_last) begin
          sig_q       <= acc_next;
          sig_valid_q <= 1'b1;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign out_data  = cur_word;
  assign out_index = idx_q;
  assign out_last  = out_valid && at_last;
  assign sig_valid = sig_valid_q;
  assign sig       = sig_q;
  assign frame_cnt = frame_cnt_q;

endmodule
